imem_boot_loader: RTL and testbench

//  Upstream feeder for the single-cycle core's instruction memory. Accepts a byte stream
//  (valid/ready), packs little-endian 32-bit instruction words, writes them into the

---
 rtl/imem_boot_loader_pkg.sv | 26 ++
 rtl/imem_boot_loader_byte_word_packer.sv | 50 +++++
 rtl/imem_boot_loader.sv | 144 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: frame field widths
// and the loader state encoding.
package imem_boot_loader_pkg;

  localparam int FRAME_BYTE_WIDTH = 8;
  localparam int FRAME_WORD_WIDTH = 32;
  localparam int FRAME_LEN_WIDTH  = 16;
  localparam int BYTES_PER_WORD   = FRAME_WORD_WIDTH / FRAME_BYTE_WIDTH;

  localparam logic [2:0] S_LEN_LO = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  typedef enum logic [2:0] {
    ST_LEN_LO = S_LEN_LO,
    ST_LEN_HI = S_LEN_HI,
    ST_DATA   = S_DATA,
    ST_CSUM   = S_CSUM,
    ST_DONE   = S_DONE,
    ST_ERROR  = S_ERROR
  } state_t;

endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Assembles four accepted bytes (little-endian) into one 32-bit word and emits
// it as a registered single-cycle word_valid pulse.
module imem_boot_loader_byte_word_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic [7:0]  i_byte,
  input  logic        i_accept,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_byte_cnt;
  logic [23:0] r_low_bytes;
  logic        r_word_valid;
  logic [31:0] r_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_cnt   <= 2'd0;
      r_low_bytes  <= 24'd0;
      r_word_valid <= 1'b0;
      r_word       <= 32'd0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clear) begin
        r_byte_cnt  <= 2'd0;
        r_low_bytes <= 24'd0;
      end else if (i_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        case (r_byte_cnt)
          2'd0: r_low_bytes[7:0]   <= i_byte;
          2'd1: r_low_bytes[15:8]  <= i_byte;
          2'd2: r_low_bytes[23:16] <= i_byte;
          default: begin
            // Last byte goes straight into the output word, so no extra cycle is spent.
            r_word       <= {i_byte, r_low_bytes};
            r_word_valid <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a length/data/checksum byte frame, writes packed words into
// instruction RAM and releases the core from reset once a good image is in place.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = FRAME_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  start,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error
);

  localparam logic [LEN_WIDTH:0] MAX_WORDS = (LEN_WIDTH+1)'(1 << ADDR_WIDTH);

  state_t                  r_state;
  logic [7:0]              r_len_lo;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [LEN_WIDTH+1:0]    r_data_cnt;
  logic [7:0]              r_csum;
  logic [ADDR_WIDTH-1:0]   r_word_idx;
  logic                    r_in_ready;
  logic                    r_done;
  logic                    r_error;
  logic                    r_core_reset;

  logic                    w_accept;
  logic                    w_data_accept;
  logic                    w_restart;
  logic [LEN_WIDTH-1:0]    w_header_len;
  logic [LEN_WIDTH-1:0]    w_len_m1;
  logic                    w_last_data;
  logic                    w_overflow;
  logic                    w_word_valid;
  logic [31:0]             w_word;

  assign w_accept      = in_valid & r_in_ready;
  assign w_data_accept = w_accept & (r_state == ST_DATA);
  assign w_restart     = start & ((r_state == ST_DONE) | (r_state == ST_ERROR));
  assign w_header_len  = LEN_WIDTH'({in_data, r_len_lo});
  assign w_len_m1      = r_len - LEN_WIDTH'(1);
  // Last data byte is byte 3 of word N-1, i.e. byte count 4N-1.
  assign w_last_data   = (r_data_cnt == {w_len_m1, 2'b11});
  assign w_overflow    = ({1'b0, w_header_len} > MAX_WORDS);

  imem_boot_loader_byte_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_restart),
    .i_byte       (in_data),
    .i_accept     (w_data_accept),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_LEN_LO;
      r_len_lo     <= 8'd0;
      r_len        <= '0;
      r_data_cnt   <= '0;
      r_csum       <= 8'd0;
      r_word_idx   <= '0;
      r_in_ready   <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_core_reset <= 1'b1;
    end else if (w_restart) begin
      r_state      <= ST_LEN_LO;
      r_len_lo     <= 8'd0;
      r_len        <= '0;
      r_data_cnt   <= '0;
      r_csum       <= 8'd0;
      r_word_idx   <= '0;
      r_in_ready   <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_core_reset <= 1'b1;
    end else begin
      // Address advances after each write cycle so imem_addr names the word being written.
      if (w_word_valid) begin
        r_word_idx <= r_word_idx + ADDR_WIDTH'(1);
      end
      if (w_accept) begin
        case (r_state)
          ST_LEN_LO: begin
            r_len_lo <= in_data;
            r_state  <= ST_LEN_HI;
          end
          ST_LEN_HI: begin
            r_len <= w_header_len;
            if (w_overflow) begin
              r_state    <= ST_ERROR;
              r_in_ready <= 1'b0;
              r_error    <= 1'b1;
            end else if (w_header_len == '0) begin
              r_state <= ST_CSUM;
            end else begin
              r_state <= ST_DATA;
            end
          end
          ST_DATA: begin
            r_csum     <= r_csum ^ in_data;
            r_data_cnt <= r_data_cnt + (LEN_WIDTH+2)'(1);
            if (w_last_data) begin
              r_state <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            r_in_ready <= 1'b0;
            if (in_data == r_csum) begin
              r_state      <= ST_DONE;
              r_done       <= 1'b1;
              r_core_reset <= 1'b0;
            end else begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign imem_we    = w_word_valid;
  assign imem_addr  = r_word_idx;
  assign imem_wdata = w_word;
  assign core_reset = r_core_reset;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: frame vectors from a table plus
// hand-written sequences for length boundary, input gaps and mid-load reset.
module tb_imem_boot_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          start;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_reset;
  logic          done;
  logic          error;

  imem_boot_loader #(.ADDR_WIDTH(AW), .LEN_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .start      (start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  nbytes;
    logic [95:0] bytes;     // byte b of the frame at [8b+7:8b]
    logic [1:0]  nwr;
    logic [63:0] wr;        // expected word w at [32w+31:32w], written to address w
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t          vecs [0:3];
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [7:0]    frame_q[$];
  logic [39:0]   wq[$];
  logic [39:0]   exp_q[$];

  always @(negedge clk) begin
    if (imem_we === 1'b1) wq.push_back({imem_addr, imem_wdata});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL send_byte_timeout: got in_ready=%0b for 50 cycles, required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input int gap_pct);
    int n;
    foreach (frame_q[k]) begin
      send_byte(frame_q[k]);
      if ($urandom_range(0, 99) < gap_pct) begin
        n = $urandom_range(1, 3);
        repeat (n) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwrites"}, 64'(wq.size()), 64'(exp_q.size()));
    foreach (exp_q[k]) begin
      if (k < wq.size()) check($sformatf("%s_wr%0d", tag, k), 64'(wq[k]), 64'(exp_q[k]));
    end
  endtask

  // Builds frame_q and exp_q for an image of nwords words from img bytes.
  task automatic build_image(input int nwords, input logic [7:0] img [], input logic [7:0] cs_xor);
    logic [7:0] cs;
    cs = 8'h00;
    frame_q.delete();
    exp_q.delete();
    frame_q.push_back(8'(nwords));
    frame_q.push_back(8'(nwords >> 8));
    for (int w = 0; w < nwords; w++) begin
      for (int b = 0; b < 4; b++) begin
        frame_q.push_back(img[4*w+b]);
        cs = cs ^ img[4*w+b];
      end
      exp_q.push_back({AW'(w), img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]});
    end
    frame_q.push_back(cs ^ cs_xor);
  endtask

  initial begin
    logic [7:0] img [];
    vec_t v;

    vecs[0] = '{nbytes: 4'd11, bytes: 96'h00B0_0020_0593_0010_0513_0002,
                nwr: 2'd2, wr: 64'h00200593_00100513, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{nbytes: 4'd11, bytes: 96'h0000_0020_0593_0010_0513_0002,
                nwr: 2'd2, wr: 64'h00200593_00100513, exp_done: 1'b0, exp_err: 1'b1};
    vecs[2] = '{nbytes: 4'd3, bytes: 96'h0,
                nwr: 2'd0, wr: 64'h0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[3] = '{nbytes: 4'd2, bytes: 96'h0101,
                nwr: 2'd0, wr: 64'h0, exp_done: 1'b0, exp_err: 1'b1};

    in_data  = 8'h00;
    in_valid = 1'b0;
    start    = 1'b0;
    reset    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_in_ready",   64'(in_ready),   64'd1);
    check("rst_imem_we",    64'(imem_we),    64'd0);
    check("rst_imem_addr",  64'(imem_addr),  64'd0);
    check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_done",       64'(done),       64'd0);
    check("rst_error",      64'(error),      64'd0);

    // Table: good image, bad checksum, empty image, length overflow.
    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      wq.delete();
      exp_q.delete();
      frame_q.delete();
      for (int b = 0; b < int'(v.nbytes); b++) frame_q.push_back(v.bytes[8*b +: 8]);
      for (int w = 0; w < int'(v.nwr); w++) exp_q.push_back({AW'(w), v.wr[32*w +: 32]});
      send_frame(0);
      check($sformatf("v%0d_done", i),       64'(done),       64'(v.exp_done));
      check($sformatf("v%0d_error", i),      64'(error),      64'(v.exp_err));
      check($sformatf("v%0d_core_reset", i), 64'(core_reset), 64'(!v.exp_done));
      check($sformatf("v%0d_in_ready", i),   64'(in_ready),   64'd0);
      repeat (2) @(posedge clk);
      #1;
      compare_writes($sformatf("v%0d", i));
      $display("vector %0d: %0d bytes, %0d writes, done=%0b error=%0b", i, v.nbytes, wq.size(), done, error);
      pulse_start();
      check($sformatf("v%0d_restart_done", i),  64'(done),       64'd0);
      check($sformatf("v%0d_restart_error", i), 64'(error),      64'd0);
      check($sformatf("v%0d_restart_crst", i),  64'(core_reset), 64'd1);
      check($sformatf("v%0d_restart_rdy", i),   64'(in_ready),   64'd1);
    end

    // Largest legal image: N = 2**AW words, last write lands at the top address.
    img = new[1024];
    for (int k = 0; k < 1024; k++) img[k] = 8'(k);
    build_image(256, img, 8'h00);
    wq.delete();
    send_frame(0);
    check("nmax_done", 64'(done), 64'd1);
    compare_writes("nmax");
    $display("max image: %0d writes, done=%0b", wq.size(), done);
    pulse_start();

    // 16-word random image, first without gaps then with 50% valid gaps.
    img = new[64];
    for (int k = 0; k < 64; k++) img[k] = 8'($urandom_range(0, 255));
    build_image(16, img, 8'h00);
    for (int pass = 0; pass < 2; pass++) begin
      wq.delete();
      send_frame(pass == 0 ? 0 : 50);
      check($sformatf("rand%0d_done", pass), 64'(done), 64'd1);
      compare_writes($sformatf("rand%0d", pass));
      $display("random image pass %0d: %0d writes, done=%0b", pass, wq.size(), done);
      pulse_start();
    end

    // Reset after six data bytes, then a full good image.
    wq.delete();
    frame_q.delete();
    for (int b = 0; b < 8; b++) frame_q.push_back(vecs[0].bytes[8*b +: 8]);
    send_frame(0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_in_ready",   64'(in_ready),   64'd1);
    check("midrst_core_reset", 64'(core_reset), 64'd1);
    check("midrst_done",       64'(done),       64'd0);
    check("midrst_imem_addr",  64'(imem_addr),  64'd0);
    check("midrst_imem_wdata", 64'(imem_wdata), 64'd0);
    check("midrst_partial_nwr", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) check("midrst_partial_wr0", 64'(wq[0]), 64'({8'h00, 32'h00100513}));
    $display("mid-load reset: %0d writes before reset", wq.size());
    wq.delete();
    exp_q.delete();
    exp_q.push_back({8'h00, 32'h00100513});
    exp_q.push_back({8'h01, 32'h00200593});
    frame_q.delete();
    for (int b = 0; b < 11; b++) frame_q.push_back(vecs[0].bytes[8*b +: 8]);
    send_frame(0);
    check("reload_done",       64'(done),       64'd1);
    check("reload_core_reset", 64'(core_reset), 64'd0);
    compare_writes("reload");
    $display("reload after reset: %0d writes, done=%0b", wq.size(), done);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
